// File: rtl/sprite_compositor_if.sv
// Pixel-path bundle for sprite_compositor: sync/background in, sprite ROM address/data, composited RGB out.
// master = pixel source, shadow registers and sprite ROMs; slave = the compositor.
interface sprite_compositor_if #(
    parameter int NUM_LAYERS  = 4,
    parameter int COORD_W     = 10,
    parameter int COLOR_W     = 8,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 16,
    parameter int ANIM_FRAMES = 2
);
    localparam int U_W  = $clog2(SPR_W);
    localparam int V_W  = $clog2(SPR_H);
    localparam int AF_W = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;

    logic                              frame_start;
    logic                              anim_tick;
    logic                              pix_valid;
    logic [COORD_W-1:0]                x;
    logic [COORD_W-1:0]                y;
    logic [3*COLOR_W-1:0]              bg_rgb;
    logic [NUM_LAYERS*COORD_W-1:0]     pos_x_sh;
    logic [NUM_LAYERS*COORD_W-1:0]     pos_y_sh;
    logic [NUM_LAYERS-1:0]             en_sh;
    logic [NUM_LAYERS*U_W-1:0]         spr_u;
    logic [NUM_LAYERS*V_W-1:0]         spr_v;
    logic [AF_W-1:0]                   anim_frame;
    logic [NUM_LAYERS*3*COLOR_W-1:0]   layer_rgb;
    logic [COLOR_W-1:0]                r;
    logic [COLOR_W-1:0]                g;
    logic [COLOR_W-1:0]                b;
    logic                              out_valid;
    logic                              collide;

    modport master (
        output frame_start, anim_tick, pix_valid, x, y, bg_rgb,
        output pos_x_sh, pos_y_sh, en_sh, layer_rgb,
        input  spr_u, spr_v, anim_frame, r, g, b, out_valid, collide
    );

    modport slave (
        input  frame_start, anim_tick, pix_valid, x, y, bg_rgb,
        input  pos_x_sh, pos_y_sh, en_sh, layer_rgb,
        output spr_u, spr_v, anim_frame, r, g, b, out_valid, collide
    );
endinterface

// File: rtl/sprite_compositor.sv
// N-layer sprite compositor: 3-stage pipeline (hit/address, ROM wait, priority mux) over the background.
// Optional layer-0 collision detection is built only when SPRITE_COLLISION_EN is defined.
module sprite_compositor #(
    parameter int                    NUM_LAYERS  = 4,
    parameter int                    COORD_W     = 10,
    parameter int                    COLOR_W     = 8,
    parameter int                    SPR_W       = 32,
    parameter int                    SPR_H       = 16,
    parameter int                    ANIM_FRAMES = 2,
    parameter logic [3*COLOR_W-1:0]  KEY_RGB     = 24'hFF00FF
) (
    input  logic               clk,
    input  logic               rst_n,
    sprite_compositor_if.slave bus
);
    localparam int RGB_W = 3 * COLOR_W;
    localparam int U_W   = $clog2(SPR_W);
    localparam int V_W   = $clog2(SPR_H);
    localparam int AF_W  = (ANIM_FRAMES > 1) ? $clog2(ANIM_FRAMES) : 1;
    localparam int EXT_W = COORD_W + 1;

    typedef logic [NUM_LAYERS-1:0][COORD_W-1:0] coord_vec_t;

    coord_vec_t                         act_x_reg;
    coord_vec_t                         act_y_reg;
    logic [NUM_LAYERS-1:0]              act_en_reg;
    coord_vec_t                         eff_x;
    coord_vec_t                         eff_y;
    logic [NUM_LAYERS-1:0]              eff_en;

    logic [NUM_LAYERS-1:0]              hit_next;
    logic [NUM_LAYERS-1:0][U_W-1:0]     u_next;
    logic [NUM_LAYERS-1:0][V_W-1:0]     v_next;
    logic [EXT_W-1:0]                   x_ext;
    logic [EXT_W-1:0]                   y_ext;

    logic [NUM_LAYERS-1:0]              hit1_reg;
    logic [NUM_LAYERS-1:0][U_W-1:0]     spr_u_reg;
    logic [NUM_LAYERS-1:0][V_W-1:0]     spr_v_reg;
    logic                               pv1_reg;
    logic [RGB_W-1:0]                   bg1_reg;

    logic [NUM_LAYERS-1:0]              hit2_reg;
    logic                               pv2_reg;
    logic [RGB_W-1:0]                   bg2_reg;

    logic [NUM_LAYERS-1:0][RGB_W-1:0]   rom_rgb;
    logic [NUM_LAYERS-1:0]              opaque;
    logic [RGB_W-1:0]                   win_rgb;
    logic [RGB_W-1:0]                   rgb_reg;
    logic                               out_valid_reg;

    logic                               tick_d_reg;
    logic                               tick_rise;
    logic                               pending_reg;
    logic [AF_W-1:0]                    frame_reg;

    // Shadow registers are copied on frame_start; the same pixel already sees them via eff_*.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_x_reg  <= '0;
            act_y_reg  <= '0;
            act_en_reg <= '0;
        end else if (bus.frame_start) begin
            act_x_reg  <= bus.pos_x_sh;
            act_y_reg  <= bus.pos_y_sh;
            act_en_reg <= bus.en_sh;
        end
    end

    assign eff_x  = bus.frame_start ? coord_vec_t'(bus.pos_x_sh) : act_x_reg;
    assign eff_y  = bus.frame_start ? coord_vec_t'(bus.pos_y_sh) : act_y_reg;
    assign eff_en = bus.frame_start ? bus.en_sh : act_en_reg;

    assign x_ext = {1'b0, bus.x};
    assign y_ext = {1'b0, bus.y};

    // One extra bit on the window bounds so sprites hanging off the right/bottom clip instead of wrapping.
    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_hit
        logic [EXT_W-1:0]   lo_x;
        logic [EXT_W-1:0]   hi_x;
        logic [EXT_W-1:0]   lo_y;
        logic [EXT_W-1:0]   hi_y;
        logic [COORD_W-1:0] dx;
        logic [COORD_W-1:0] dy;

        assign lo_x = {1'b0, eff_x[gi]};
        assign hi_x = lo_x + EXT_W'(SPR_W);
        assign lo_y = {1'b0, eff_y[gi]};
        assign hi_y = lo_y + EXT_W'(SPR_H);

        assign hit_next[gi] = eff_en[gi] & bus.pix_valid
                            & (x_ext >= lo_x) & (x_ext < hi_x)
                            & (y_ext >= lo_y) & (y_ext < hi_y);

        assign dx = bus.x - eff_x[gi];
        assign dy = bus.y - eff_y[gi];
        assign u_next[gi] = hit_next[gi] ? dx[U_W-1:0] : '0;
        assign v_next[gi] = hit_next[gi] ? dy[V_W-1:0] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit1_reg  <= '0;
            spr_u_reg <= '0;
            spr_v_reg <= '0;
            pv1_reg   <= 1'b0;
            bg1_reg   <= '0;
            hit2_reg  <= '0;
            pv2_reg   <= 1'b0;
            bg2_reg   <= '0;
        end else begin
            hit1_reg  <= hit_next;
            spr_u_reg <= u_next;
            spr_v_reg <= v_next;
            pv1_reg   <= bus.pix_valid;
            bg1_reg   <= bus.bg_rgb;
            hit2_reg  <= hit1_reg;
            pv2_reg   <= pv1_reg;
            bg2_reg   <= bg1_reg;
        end
    end

    assign bus.spr_u = spr_u_reg;
    assign bus.spr_v = spr_v_reg;

    // ROM data returned for the stage-1 addresses lines up with the stage-2 registers.
    assign rom_rgb = bus.layer_rgb;

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_opaque
        assign opaque[gi] = hit2_reg[gi] & (rom_rgb[gi] != KEY_RGB);
    end

    // Walk from lowest priority up so layer 0 is the last (winning) assignment.
    always_comb begin
        win_rgb = bg2_reg;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (opaque[i]) begin
                win_rgb = rom_rgb[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_reg       <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            out_valid_reg <= pv2_reg;
            rgb_reg       <= pv2_reg ? win_rgb : '0;
        end
    end

    assign bus.r         = rgb_reg[RGB_W-1 -: COLOR_W];
    assign bus.g         = rgb_reg[2*COLOR_W-1 -: COLOR_W];
    assign bus.b         = rgb_reg[COLOR_W-1:0];
    assign bus.out_valid = out_valid_reg;

    // Any number of tick edges within a frame collapse into one pending step.
    assign tick_rise = bus.anim_tick & ~tick_d_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_d_reg  <= 1'b0;
            pending_reg <= 1'b0;
            frame_reg   <= '0;
        end else begin
            tick_d_reg <= bus.anim_tick;
            if (bus.frame_start) begin
                pending_reg <= 1'b0;
                if (pending_reg | tick_rise) begin
                    frame_reg <= (frame_reg == AF_W'(ANIM_FRAMES - 1)) ? '0 : frame_reg + 1'b1;
                end
            end else if (tick_rise) begin
                pending_reg <= 1'b1;
            end
        end
    end

    assign bus.anim_frame = frame_reg;

`ifdef SPRITE_COLLISION_EN
    logic collide_reg;
    logic collide_det;

    assign collide_det = opaque[0] & (|opaque[NUM_LAYERS-1:1]);

    // Sticky per frame; a detection on the frame_start cycle takes priority over the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            collide_reg <= 1'b0;
        end else if (collide_det) begin
            collide_reg <= 1'b1;
        end else if (bus.frame_start) begin
            collide_reg <= 1'b0;
        end
    end

    assign bus.collide = collide_reg;
`else
    assign bus.collide = 1'b0;
`endif

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: per-cycle comparison against a behavioural pixel model,
// plus hand-computed expectations for the key scenarios.
module tb_sprite_compositor;
    localparam int NL  = 4;
    localparam int CW  = 10;
    localparam int CLW = 8;
    localparam int SW  = 32;
    localparam int SH  = 16;
    localparam int AF  = 2;
    localparam int UW  = 5;
    localparam int VW  = 4;
    localparam logic [23:0] KEY = 24'hFF00FF;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sprite_compositor_if #(
        .NUM_LAYERS(NL), .COORD_W(CW), .COLOR_W(CLW),
        .SPR_W(SW), .SPR_H(SH), .ANIM_FRAMES(AF)
    ) bus ();

    sprite_compositor #(
        .NUM_LAYERS(NL), .COORD_W(CW), .COLOR_W(CLW),
        .SPR_W(SW), .SPR_H(SH), .ANIM_FRAMES(AF), .KEY_RGB(KEY)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [23:0] rom_color [NL];
    logic        tick_lvl = 1'b0;

    // Sprite ROM stand-in: one colour per layer, registered one cycle after the address.
    always @(posedge clk) begin
        for (int i = 0; i < NL; i++) begin
            bus.layer_rgb[i*24 +: 24] <= rom_color[i];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_ax [NL];
    int          m_ay [NL];
    bit          m_en [NL];
    bit          h_valid [2];
    logic [23:0] h_rgb [2];
    bit          h_det [2];
    int          m_frame;
    bit          m_pending, m_prev_tick, m_collide;
    int          mx, my, first_hit, eu, ev;
    bit          hit, opq, l0_opq, other_opq, rise;
    logic [23:0] cur_rgb;

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            for (int i = 0; i < NL; i++) begin
                m_ax[i] = 0; m_ay[i] = 0; m_en[i] = 1'b0;
            end
            for (int j = 0; j < 2; j++) begin
                h_valid[j] = 1'b0; h_rgb[j] = '0; h_det[j] = 1'b0;
            end
            m_frame = 0; m_pending = 1'b0; m_prev_tick = 1'b0; m_collide = 1'b0;
            chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("rst_rgb", {8'h0, bus.r, bus.g, bus.b}, 32'd0);
        end else begin
            if (bus.frame_start) begin
                for (int i = 0; i < NL; i++) begin
                    m_ax[i] = int'(bus.pos_x_sh[i*CW +: CW]);
                    m_ay[i] = int'(bus.pos_y_sh[i*CW +: CW]);
                    m_en[i] = bus.en_sh[i];
                end
            end
            mx = int'(bus.x);
            my = int'(bus.y);
            first_hit = -1; l0_opq = 1'b0; other_opq = 1'b0;
            for (int i = 0; i < NL; i++) begin
                hit = m_en[i] && bus.pix_valid && (mx >= m_ax[i]) && (mx < m_ax[i] + SW)
                      && (my >= m_ay[i]) && (my < m_ay[i] + SH);
                eu = hit ? mx - m_ax[i] : 0;
                ev = hit ? my - m_ay[i] : 0;
                chk("spr_u", {27'b0, bus.spr_u[i*UW +: UW]}, eu);
                chk("spr_v", {28'b0, bus.spr_v[i*VW +: VW]}, ev);
                opq = hit && (rom_color[i] != KEY);
                if (opq && first_hit < 0) first_hit = i;
                if (opq && i == 0) l0_opq = 1'b1;
                if (opq && i != 0) other_opq = 1'b1;
            end
            cur_rgb = !bus.pix_valid ? 24'h0 : (first_hit >= 0) ? rom_color[first_hit] : bus.bg_rgb;

            chk("out_valid", {31'b0, bus.out_valid}, {31'b0, h_valid[1]});
            chk("rgb", {8'h0, bus.r, bus.g, bus.b}, {8'h0, h_rgb[1]});

`ifdef SPRITE_COLLISION_EN
            if (h_det[1]) m_collide = 1'b1;
            else if (bus.frame_start) m_collide = 1'b0;
`else
            m_collide = 1'b0;
`endif
            chk("collide", {31'b0, bus.collide}, {31'b0, m_collide});

            rise = bus.anim_tick && !m_prev_tick;
            m_prev_tick = bus.anim_tick;
            if (bus.frame_start) begin
                if (m_pending || rise) m_frame = (m_frame + 1) % AF;
                m_pending = 1'b0;
            end else if (rise) begin
                m_pending = 1'b1;
            end
            chk("anim_frame", {31'b0, bus.anim_frame}, m_frame);

            h_valid[1] = h_valid[0]; h_rgb[1] = h_rgb[0]; h_det[1] = h_det[0];
            h_valid[0] = bus.pix_valid; h_rgb[0] = cur_rgb; h_det[0] = l0_opq && other_opq;
        end
    end

    // ---------------- stimulus ----------------
    logic [NL*UW-1:0] cap_u;
    logic [NL*VW-1:0] cap_v;

    task automatic px(input bit fs, input bit pv, input int xx, input int yy, input logic [23:0] bg);
        @(negedge clk);
        bus.frame_start = fs;
        bus.anim_tick   = tick_lvl;
        bus.pix_valid   = pv;
        bus.x           = CW'(xx);
        bus.y           = CW'(yy);
        bus.bg_rgb      = bg;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) px(1'b0, 1'b0, 0, 0, 24'h0);
    endtask

    // Apply one pixel, capture its stage-1 addresses, then wait until its colour is on r/g/b.
    task automatic shot(input bit fs, input int xx, input int yy, input logic [23:0] bg);
        px(fs, 1'b1, xx, yy, bg);
        idle(1);
        cap_u = bus.spr_u;
        cap_v = bus.spr_v;
        idle(2);
    endtask

    task automatic set_layer(input int i, input int xx, input int yy, input bit en);
        bus.pos_x_sh[i*CW +: CW] = CW'(xx);
        bus.pos_y_sh[i*CW +: CW] = CW'(yy);
        bus.en_sh[i]             = en;
    endtask

    task automatic chk_rgb(input string name, input logic [23:0] exp);
        chk(name, {8'h0, bus.r, bus.g, bus.b}, {8'h0, exp});
    endtask

    initial begin
        bus.frame_start = 1'b0; bus.anim_tick = 1'b0; bus.pix_valid = 1'b0;
        bus.x = '0; bus.y = '0; bus.bg_rgb = '0;
        bus.pos_x_sh = '0; bus.pos_y_sh = '0; bus.en_sh = '0;
        rom_color[0] = 24'hFFFF00; rom_color[1] = 24'h00FF00;
        rom_color[2] = 24'h0000FF; rom_color[3] = 24'h123456;

        repeat (3) @(negedge clk);
        chk("reset_rgb", {8'h0, bus.r, bus.g, bus.b}, 32'd0);
        chk("reset_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("reset_spr_u", {12'b0, bus.spr_u}, 32'd0);
        chk("reset_anim", {31'b0, bus.anim_frame}, 32'd0);
        chk("reset_collide", {31'b0, bus.collide}, 32'd0);
        rst_n = 1'b1;

        // Background only.
        px(1'b1, 1'b0, 0, 0, 24'h0);
        shot(1'b0, 5, 5, 24'h102030);
        chk("bg_spr_u", {12'b0, cap_u}, 32'd0);
        chk("bg_spr_v", {16'b0, cap_v}, 32'd0);
        chk_rgb("bg_rgb", 24'h102030);
        chk("bg_valid", {31'b0, bus.out_valid}, 32'd1);

        // Single sprite, inside and just past its right edge.
        set_layer(0, 304, 336, 1'b1);
        px(1'b1, 1'b0, 0, 0, 24'h0);
        shot(1'b0, 305, 337, 24'h445566);
        chk("l0_spr_u", {27'b0, cap_u[UW-1:0]}, 32'd1);
        chk("l0_spr_v", {28'b0, cap_v[VW-1:0]}, 32'd1);
        chk_rgb("l0_rgb", 24'hFFFF00);
        shot(1'b0, 336, 337, 24'h445566);
        chk_rgb("l0_right_miss", 24'h445566);

        // Overlap with layer 0 transparent, then opaque.
        set_layer(1, 300, 330, 1'b1);
        rom_color[0] = KEY;
        px(1'b1, 1'b0, 0, 0, 24'h0);
        shot(1'b0, 310, 340, 24'h010101);
        chk_rgb("key_show_l1", 24'h00FF00);
        rom_color[0] = 24'hFFFF00;
        idle(3);
        shot(1'b0, 310, 340, 24'h010101);
        chk_rgb("l0_over_l1", 24'hFFFF00);

        // Mid-frame shadow change only lands at frame_start, including that pixel.
        set_layer(0, 400, 336, 1'b1);
        shot(1'b0, 305, 337, 24'h020202);
        chk_rgb("shadow_hold", 24'hFFFF00);
        shot(1'b1, 305, 337, 24'h020202);
        chk_rgb("shadow_fs_pixel", 24'h00FF00);
        shot(1'b0, 401, 337, 24'h020202);
        chk_rgb("shadow_moved", 24'hFFFF00);

        // Right-edge clipping without wrap.
        set_layer(0, 1020, 0, 1'b1);
        set_layer(1, 0, 0, 1'b0);
        px(1'b1, 1'b0, 0, 0, 24'h0);
        shot(1'b0, 1023, 0, 24'h0A0B0C);
        chk("clip_spr_u", {27'b0, cap_u[UW-1:0]}, 32'd3);
        chk_rgb("clip_hit", 24'hFFFF00);
        shot(1'b0, 0, 0, 24'h0A0B0C);
        chk_rgb("no_wrap", 24'h0A0B0C);

        // Layers 0 and 2 overlap.
        set_layer(0, 100, 100, 1'b1);
        set_layer(2, 110, 100, 1'b1);
        px(1'b1, 1'b0, 0, 0, 24'h0);
        shot(1'b0, 115, 105, 24'h030303);
        chk_rgb("overlap_l0", 24'hFFFF00);
        idle(2);
`ifdef SPRITE_COLLISION_EN
        chk("collide_set", {31'b0, bus.collide}, 32'd1);
`else
        chk("collide_tied", {31'b0, bus.collide}, 32'd0);
`endif
        px(1'b1, 1'b0, 0, 0, 24'h0);
        idle(1);
        chk("collide_clear", {31'b0, bus.collide}, 32'd0);

        // Sweeps across sprite edges, layer 0 opaque and then keyed out.
        set_layer(3, 90, 98, 1'b1);
        px(1'b1, 1'b0, 0, 0, 24'h0);
        for (int pass = 0; pass < 2; pass++) begin
            rom_color[0] = (pass == 0) ? 24'hFFFF00 : KEY;
            idle(3);
            for (int yi = 0; yi < 4; yi++) begin
                for (int xx = 85; xx < 146; xx++) begin
                    px(1'b0, 1'b1, xx, (yi == 0) ? 99 : (yi == 1) ? 105 : (yi == 2) ? 115 : 116,
                       {8'(xx), 8'(yi), 8'h5A});
                end
            end
        end
        rom_color[0] = 24'hFFFF00;
        idle(3);

        // Animation: three ticks in a frame step once; tick with frame_start wraps.
        chk("anim_start", {31'b0, bus.anim_frame}, 32'd0);
        for (int t = 0; t < 3; t++) begin
            tick_lvl = 1'b1; idle(2);
            tick_lvl = 1'b0; idle(2);
        end
        chk("anim_pending", {31'b0, bus.anim_frame}, 32'd0);
        px(1'b1, 1'b0, 0, 0, 24'h0);
        idle(1);
        chk("anim_step", {31'b0, bus.anim_frame}, 32'd1);
        px(1'b1, 1'b0, 0, 0, 24'h0);
        idle(1);
        chk("anim_no_tick", {31'b0, bus.anim_frame}, 32'd1);
        tick_lvl = 1'b1;
        px(1'b1, 1'b0, 0, 0, 24'h0);
        idle(1);
        chk("anim_wrap", {31'b0, bus.anim_frame}, 32'd0);
        tick_lvl = 1'b0;
        idle(2);

        // Reset in the middle of a line of visible pixels.
        for (int xx = 0; xx < 4; xx++) px(1'b0, 1'b1, xx, 200, 24'h778899);
        chk("pre_reset_valid", {31'b0, bus.out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_rgb", {8'h0, bus.r, bus.g, bus.b}, 32'd0);
        chk("midreset_valid", {31'b0, bus.out_valid}, 32'd0);
        idle(2);
        rst_n = 1'b1;
        shot(1'b0, 305, 337, 24'h010203);
        chk_rgb("post_reset_bg", 24'h010203);
        chk("post_reset_anim", {31'b0, bus.anim_frame}, 32'd0);
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
